bus_arbiter8: RTL and testbench
===============================

BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 SHALL have parameter: MAX_BEATS, 16, accepted beats per grant before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: req  input  8  per-requester bus request, level, held for the whole transfer.
REQ-005 SHALL have port: last  input  8  per-requester end-of-burst flag, qualified by that requester's accepted beat.
REQ-006 SHALL have port: bus_ready  input  1  downstream accepts the current beat.
REQ-007 SHALL have port: gnt  output  8  one-hot grant, or all zero.
REQ-008 SHALL have port: sel  output  3  owner index driving the 8-to-1 32-bit mux selects (sel[2]=s2, sel[1]=s1, sel[0]=s0).
REQ-009 SHALL have port: bus_valid  output  1  current mux output is a valid beat.
REQ-010 SHALL have port: busy  output  1  a grant is active.
REQ-011 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement states IDLE and GRANT.
REQ-013 In IDLE with req != 0, SHALL select the first set req bit at or after ptr, searching upward modulo 8, and enter GRANT next cycle with gnt/sel/owner registered.
REQ-014 Latency from req sampled in IDLE to gnt asserted SHALL be exactly 1 cycle.
REQ-015 In GRANT: gnt = one-hot(owner), busy = 1, bus_valid = req[owner].
REQ-016 A beat SHALL be accepted when bus_valid && bus_ready.
REQ-017 GRANT SHALL end on an accepted beat with last[owner]=1, or when req[owner]=0 (abandon). Either event SHALL move to IDLE and set ptr <= owner+1 mod 8, with wrap 7->0.
REQ-018 After every grant end, the arbiter SHALL spend exactly one IDLE cycle (gnt=0, bus_valid=0) before the next grant.
REQ-019 req/last bits of non-owners SHALL be ignored during GRANT.
REQ-020 sel SHALL hold the last owner index while IDLE.
REQ-021 The owner SHALL not change while in GRANT.
REQ-022 With a steady request set, each requester SHALL wait at most 7 other grants (round-robin fairness).

Reset
REQ-023 With rst_n=0 at a clock edge, SHALL enter IDLE with ptr=0, sel=0, gnt=0, bus_valid=0, busy=0, timeout=0 and beat count=0.
REQ-024 Reset during GRANT SHALL abort the transfer with no timeout pulse.
REQ-025 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-026 With macro ARB_TIMEOUT_EN defined, accepted beats in the current grant SHALL be counted. The MAX_BEATS-th accepted beat without last SHALL force GRANT->IDLE, pulse timeout for 1 cycle and advance ptr as in REQ-017.
REQ-027 With ARB_TIMEOUT_EN undefined, there SHALL be no beat counter, timeout SHALL be tied 0 and grants SHALL be unbounded.
REQ-028 The count SHALL clear on grant entry. If last and the limit coincide, the release SHALL be normal with timeout=0.

Structure
REQ-029 Package arb_pkg SHALL hold NUM_REQ=8, SEL_W=3 and the state encoding constants.
REQ-030 Combinational sub-module rr_pick8 (inputs req[7:0], ptr[2:0]; outputs found, idx[2:0]) SHALL perform the rotate-priority search.

Verification
REQ-031 Reset, then req=8'h01 with bus_ready=1 and last[0] set on the 3rd beat -> gnt=8'h01 one cycle after req, sel=0, 3 beats accepted, gnt=0 the next cycle.
REQ-032 req=8'hFF held, each owner sends 1 beat with last -> grant order 0,1,...,7,0 with one idle cycle between grants.
REQ-033 ptr=6, req=8'h41 -> requester 6 granted (sel=6), then requester 0 (wrap).
REQ-034 Owner 3 with bus_ready=0 for 5 cycles -> bus_valid=1 and gnt held, no beat accepted; owner 3 then drops req -> IDLE, ptr=4.
REQ-035 ARB_TIMEOUT_EN, MAX_BEATS=16, last never set -> release after 16th accepted beat, timeout=1 for exactly 1 cycle. Without the macro -> grant continues, timeout stays 0.
REQ-036 rst_n=0 asserted mid-GRANT (owner 5) -> next cycle all outputs 0, sel=0; req=8'h20 then regranted after 1 cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-requester round-robin bus arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority search: first set req bit at or after ptr, wrapping modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from farthest offset down so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter granting one of eight requesters a shared 32-bit bus mux.
// Optional per-grant beat limit with timeout pulse: define ARB_TIMEOUT_EN.
module bus_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               bus_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_valid,
  output logic               busy,
  output logic               timeout
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               busy_d;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               accept;
  logic               limit_hit;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign bus_valid = (state_q == GRANT) && req[owner_q];
  assign accept    = bus_valid && bus_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;

  // A beat carrying last takes precedence over the limit, so that release stays normal.
  assign limit_hit = accept && !last[owner_q] && (cnt_q == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d     = cnt_q + CNT_W'(1);
      timeout_d = limit_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  logic unused_max_beats;

  // Grants are unbounded; the beat limit is only meaningful with the timeout build.
  assign unused_max_beats = (MAX_BEATS != 0);
  assign limit_hit        = 1'b0;
  assign timeout          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    gnt_d   = gnt;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
          sel_d   = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        // Release on abandon, completed burst or beat limit; next search starts past owner.
        if (!req[owner_q] || (accept && last[owner_q]) || limit_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      sel     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Self-checking bench for bus_arbiter8: directed scenarios plus random traffic against a reference model.
module tb_bus_arbiter8;

  localparam int MAXB = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] last = 8'h00;
  logic       bus_ready = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic       busy;
  logic       timeout;

  bus_arbiter8 #(.MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .bus_ready (bus_ready),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, where the next search starts, beats so far.
  bit m_ok = 1'b0;
  bit m_act = 1'b0;
  bit m_to = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_sel = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok = 1'b1; m_act = 1'b0; m_to = 1'b0;
      m_ptr = 0; m_sel = 0; m_cnt = 0; m_owner = 0;
    end else begin
      m_to = 1'b0;
      if (!m_act) begin
        if (req != 8'h00) begin
          bit hit;
          hit = 1'b0;
          for (int k = 0; k < 8; k++) begin
            if (!hit && req[(m_ptr + k) % 8]) begin
              hit = 1'b1;
              m_owner = (m_ptr + k) % 8;
            end
          end
          m_act = 1'b1; m_sel = m_owner; m_cnt = 0;
        end
      end else if (!req[m_owner]) begin
        m_act = 1'b0; m_ptr = (m_owner + 1) % 8;
      end else if (bus_ready) begin
        m_cnt++;
        if (last[m_owner]) begin
          m_act = 1'b0; m_ptr = (m_owner + 1) % 8;
        end else if (TO_EN && m_cnt == MAXB) begin
          m_act = 1'b0; m_ptr = (m_owner + 1) % 8; m_to = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      logic [7:0] eg;
      eg = m_act ? (8'h01 << m_owner) : 8'h00;
      check("gnt", 32'(gnt), 32'(eg));
      check("sel", 32'(sel), 32'(m_sel));
      check("busy", 32'(busy), 32'(m_act));
      check("bus_valid", 32'(bus_valid), 32'(m_act && req[m_owner]));
      check("timeout", 32'(timeout), 32'(m_to));
    end
  end

  // Observers: beats that will be accepted at the next edge, timeout pulses, grant order.
  int acc_cnt = 0;
  int to_cnt = 0;
  bit rec = 1'b0;
  int gq[$];
  logic [7:0] gnt_prev = 8'h00;

  always @(negedge clk) begin
    if (rst_n && bus_valid && bus_ready) acc_cnt++;
    if (timeout) to_cnt++;
    if (rec && gnt != 8'h00 && gnt_prev == 8'h00) begin
      for (int i = 0; i < 8; i++) if (gnt[i]) gq.push_back(i);
    end
    gnt_prev = gnt;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check_order(input string name, input int exp[$]);
    check({name, "_len"}, 32'(gq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < gq.size(); i++)
      check(name, 32'(gq[i]), 32'(exp[i]));
  endtask

  initial begin
    int a0;
    int t0;
    int ord[$];

    // Reset state
    rst_n = 1'b0;
    cyc(); cyc();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // Single requester, three-beat burst
    rst_n = 1'b1; req = 8'h01; bus_ready = 1'b1; last = 8'h00;
    a0 = acc_cnt;
    cyc();
    check("s1_gnt", 32'(gnt), 32'h01);
    check("s1_sel", 32'(sel), 32'h0);
    cyc(); cyc();
    last = 8'h01;
    cyc();
    check("s1_end_gnt", 32'(gnt), 32'h0);
    check("s1_beats", 32'(acc_cnt - a0), 32'd3);
    req = 8'h00; last = 8'h00;
    cyc();

    // All requesting, one beat each: full rotation from requester 0
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; req = 8'hFF; last = 8'hFF; bus_ready = 1'b1;
    gq.delete(); rec = 1'b1;
    repeat (18) cyc();
    rec = 1'b0; req = 8'h00; last = 8'h00;
    ord = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    check_order("rr_order", ord);

    // Pointer at 6 then wrap to 0
    gq.delete(); rec = 1'b1;
    req = 8'h20; last = 8'h20;
    cyc(); cyc();
    req = 8'h41; last = 8'h41;
    repeat (4) cyc();
    rec = 1'b0; req = 8'h00; last = 8'h00;
    ord = '{5, 6, 0};
    check_order("wrap_order", ord);
    cyc();

    // Stalled owner 3, then abandon
    req = 8'h08; bus_ready = 1'b0; last = 8'h00;
    cyc();
    a0 = acc_cnt;
    repeat (5) cyc();
    check("stall_valid", 32'(bus_valid), 32'h1);
    check("stall_gnt", 32'(gnt), 32'h08);
    check("stall_beats", 32'(acc_cnt - a0), 32'd0);
    req = 8'h00;
    cyc();
    check("abandon_gnt", 32'(gnt), 32'h0);
    req = 8'hFF; last = 8'hFF; bus_ready = 1'b1;
    cyc();
    check("after_abandon_gnt", 32'(gnt), 32'h10);
    check("after_abandon_sel", 32'(sel), 32'd4);
    req = 8'h00; last = 8'h00;
    cyc(); cyc();

    // Beat limit
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; req = 8'h01; last = 8'h00; bus_ready = 1'b1;
    t0 = to_cnt;
    repeat (17) cyc();
    check("limit_gnt", 32'(gnt), TO_EN ? 32'h0 : 32'h01);
    check("limit_timeout", 32'(timeout), 32'(TO_EN));
    repeat (3) cyc();
    check("limit_pulses", 32'(to_cnt - t0), TO_EN ? 32'd1 : 32'd0);
    req = 8'h00;
    cyc(); cyc();

    // Reset in the middle of a grant to requester 5
    req = 8'h20; last = 8'h00; bus_ready = 1'b1;
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(bus_valid), 32'h0);
    check("midrst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    cyc();
    check("regrant_gnt", 32'(gnt), 32'h20);
    check("regrant_sel", 32'(sel), 32'd5);

    // Random traffic: frequent bursts ends first, then long bursts to reach the limit
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      if (c < 1500) last = 8'($urandom & $urandom);
      else last = ($urandom_range(0, 23) == 0) ? 8'hFF : 8'h00;
      bus_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
